// File: rtl/led_line_shifter.sv
// HUB75 row serialiser: reads one row of 2xRGB444 pixels from frame RAM and
// shifts one PWM-thresholded bit per colour per column into the panel.
module led_line_shifter #(
    parameter int unsigned COLS     = 64,
    parameter int unsigned COL_BITS = 6
) (
    input  logic                  clk_25MHz,
    input  logic                  rst,
    input  logic                  line_begin,
    input  logic [4:0]            line_addr,
    input  logic [3:0]            line_pwm,
    output logic                  line_done,
    output logic [5+COL_BITS-1:0] ram_addr,
    output logic                  ram_rd_en,
    input  logic [23:0]           ram_rdata,
    output logic                  panel_clk,
    output logic [2:0]            panel_rgb1,
    output logic [2:0]            panel_rgb2
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    state_t                state;
    logic [4:0]            row;
    logic [3:0]            pwm;
    logic [COL_BITS-1:0]   col;

    // A channel is lit when its 4-bit intensity exceeds the current PWM slice.
    function automatic logic [2:0] shade(input logic [11:0] px, input logic [3:0] slice);
        return {px[11:8] > slice, px[7:4] > slice, px[3:0] > slice};
    endfunction

    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            row        <= '0;
            pwm        <= '0;
            col        <= '0;
            line_done  <= 1'b0;
            ram_addr   <= '0;
            ram_rd_en  <= 1'b0;
            panel_clk  <= 1'b0;
            panel_rgb1 <= '0;
            panel_rgb2 <= '0;
        end else begin
            line_done <= 1'b0;
            ram_rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    panel_clk <= 1'b0;
                    if (line_begin) begin
                        row       <= line_addr;
                        pwm       <= line_pwm;
                        col       <= '0;
                        ram_addr  <= {line_addr, COL_BITS'(0)};
                        ram_rd_en <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    panel_rgb1 <= shade(ram_rdata[23:12], pwm);
                    panel_rgb2 <= shade(ram_rdata[11:0], pwm);
                    if (COLS > 1) begin
                        ram_addr  <= {row, COL_BITS'(1)};
                        ram_rd_en <= 1'b1;
                    end
                    state <= ST_LOW;
                end
                ST_LOW: begin
                    panel_clk <= 1'b1;
                    state     <= ST_HIGH;
                end
                ST_HIGH: begin
                    // Data only changes on the falling shift edge; next column's read is already back.
                    panel_clk <= 1'b0;
                    if (32'(col) < COLS - 1) begin
                        panel_rgb1 <= shade(ram_rdata[23:12], pwm);
                        panel_rgb2 <= shade(ram_rdata[11:0], pwm);
                        col        <= col + COL_BITS'(1);
                        if (32'(col) + 32'd2 < COLS) begin
                            ram_addr  <= {row, COL_BITS'(32'(col) + 32'd2)};
                            ram_rd_en <= 1'b1;
                        end
                        state <= ST_LOW;
                    end else begin
                        panel_rgb1 <= '0;
                        panel_rgb2 <= '0;
                        line_done  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_line_shifter.sv
// Scoreboard bench for led_line_shifter: stimulus queues expected reads, shift
// data and done cycles; negedge monitors pop and compare as the DUT emits them.
`timescale 1ns/1ps
module tb_led_line_shifter;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    // 64-column DUT
    logic        line_begin, line_done, ram_rd_en, panel_clk;
    logic [4:0]  line_addr;
    logic [3:0]  line_pwm;
    logic [10:0] ram_addr;
    logic [23:0] ram_rdata;
    logic [2:0]  panel_rgb1, panel_rgb2;

    // 4-column DUT
    logic        line_begin4, line_done4, ram_rd_en4, panel_clk4;
    logic [4:0]  line_addr4;
    logic [3:0]  line_pwm4;
    logic [6:0]  ram_addr4;
    logic [23:0] ram_rdata4;
    logic [2:0]  panel_rgb1_4, panel_rgb2_4;

    logic [23:0] mem [0:2047];

    logic [10:0] exp_addr[$];
    logic [5:0]  exp_rgb[$];
    int          exp_done[$];
    logic [6:0]  exp_addr4[$];
    int          exp_done4[$];
    int          rises4 = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_line_shifter #(.COLS(64), .COL_BITS(6)) dut (
        .clk_25MHz(clk), .rst(rst), .line_begin(line_begin), .line_addr(line_addr),
        .line_pwm(line_pwm), .line_done(line_done), .ram_addr(ram_addr),
        .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata), .panel_clk(panel_clk),
        .panel_rgb1(panel_rgb1), .panel_rgb2(panel_rgb2)
    );

    led_line_shifter #(.COLS(4), .COL_BITS(2)) dut4 (
        .clk_25MHz(clk), .rst(rst), .line_begin(line_begin4), .line_addr(line_addr4),
        .line_pwm(line_pwm4), .line_done(line_done4), .ram_addr(ram_addr4),
        .ram_rd_en(ram_rd_en4), .ram_rdata(ram_rdata4), .panel_clk(panel_clk4),
        .panel_rgb1(panel_rgb1_4), .panel_rgb2(panel_rgb2_4)
    );

    // Synchronous frame RAM: data valid the cycle after the address.
    always @(posedge clk) begin
        if (ram_rd_en)  ram_rdata  <= mem[ram_addr];
        if (ram_rd_en4) ram_rdata4 <= mem[11'(ram_addr4)];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=event expected=none (cycle %0d)", name, cyc);
    endtask

    // kind 0: upper R = col mod 16, lower B = 15 - col mod 16; kind 1: all 0xF; kind 2: all 0
    task automatic fill(input int kind);
        for (int a = 0; a < 2048; a++) begin
            case (kind)
                0:       mem[a] = {4'(a), 16'h0000, 4'(15 - (a % 16))};
                1:       mem[a] = 24'hFFFFFF;
                default: mem[a] = 24'h000000;
            endcase
        end
    endtask

    task automatic issue_line(input logic [4:0] row, input logic [3:0] pwm, input int kind);
        logic [3:0] v;
        logic [5:0] e;
        line_addr  = row;
        line_pwm   = pwm;
        line_begin = 1'b1;
        for (int c = 0; c < 64; c++) begin
            exp_addr.push_back({row, 6'(c)});
            v = 4'(c);
            case (kind)
                0:       e = {v > pwm, 4'b0000, (4'd15 - v) > pwm};
                1:       e = (pwm < 4'd15) ? 6'h3F : 6'h00;
                default: e = 6'h00;
            endcase
            exp_rgb.push_back(e);
        end
        exp_done.push_back(cyc + 131);
        @(posedge clk) #1;
        line_begin = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"},  32'(line_done), 0);
        check({tag, "_rd_en"}, 32'(ram_rd_en), 0);
        check({tag, "_addr"},  32'(ram_addr), 0);
        check({tag, "_pclk"},  32'(panel_clk), 0);
        check({tag, "_rgb"},   32'({panel_rgb1, panel_rgb2}), 0);
    endtask

    // Monitor for the 64-column DUT.
    logic pclk_q = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_rd_en) begin
                if (exp_addr.size() == 0) unexpected("ram_read");
                else check("ram_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
            end
            if (panel_clk && !pclk_q) begin
                if (exp_rgb.size() == 0) unexpected("panel_rise");
                else check("rgb_at_rise", 32'({panel_rgb1, panel_rgb2}), 32'(exp_rgb.pop_front()));
            end
            if (line_done) begin
                if (exp_done.size() == 0) unexpected("line_done");
                else check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
            end
        end
        pclk_q = panel_clk;
    end

    // Monitor for the 4-column DUT.
    logic pclk4_q = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_rd_en4) begin
                if (exp_addr4.size() == 0) unexpected("ram_read4");
                else check("ram_addr4", 32'(ram_addr4), 32'(exp_addr4.pop_front()));
            end
            if (panel_clk4 && !pclk4_q) rises4++;
            if (line_done4) begin
                if (exp_done4.size() == 0) unexpected("line_done4");
                else check("done_cycle4", 32'(cyc), 32'(exp_done4.pop_front()));
            end
        end
        pclk4_q = panel_clk4;
    end

    initial begin
        rst         = 1'b1;
        line_begin  = 1'b0;
        line_addr   = '0;
        line_pwm    = '0;
        line_begin4 = 1'b0;
        line_addr4  = '0;
        line_pwm4   = '0;
        fill(0);
        wait_cycles(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        wait_cycles(5);

        // Nominal line with ignored busy pulses, then a back-to-back line
        issue_line(5'd5, 4'd7, 0);
        for (int i = 2; i <= 131; i++) begin
            @(posedge clk) #1;
            line_begin = (i == 10 || i == 100);
            line_addr  = 5'd9;
            line_pwm   = 4'd0;
        end
        @(posedge clk) #1;
        issue_line(5'd5, 4'd3, 0);
        wait_cycles(135);

        // PWM boundaries
        fill(1);
        issue_line(5'd1, 4'd14, 1);
        wait_cycles(135);
        issue_line(5'd1, 4'd15, 1);
        wait_cycles(135);
        fill(2);
        issue_line(5'd1, 4'd0, 2);
        wait_cycles(135);

        // Reset on the 20th shift-clock rise
        fill(0);
        issue_line(5'd5, 4'd7, 0);
        wait_cycles(41);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        check("midrst_rises_left", 32'(exp_rgb.size()), 45);
        check("midrst_reads_left", 32'(exp_addr.size()), 43);
        check("midrst_no_done", 32'(exp_done.size()), 1);
        exp_rgb.delete();
        exp_addr.delete();
        exp_done.delete();
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(20);
        issue_line(5'd3, 4'd0, 0);
        wait_cycles(135);

        // Four-column build
        line_addr4  = 5'd2;
        line_pwm4   = 4'd0;
        line_begin4 = 1'b1;
        for (int c = 0; c < 4; c++) exp_addr4.push_back({5'd2, 2'(c)});
        exp_done4.push_back(cyc + 11);
        rises4 = 0;
        @(posedge clk) #1;
        line_begin4 = 1'b0;
        wait_cycles(15);
        check("cols4_rises", 32'(rises4), 4);

        check("left_addr",  32'(exp_addr.size()), 0);
        check("left_rgb",   32'(exp_rgb.size()), 0);
        check("left_done",  32'(exp_done.size()), 0);
        check("left_addr4", 32'(exp_addr4.size()), 0);
        check("left_done4", 32'(exp_done4.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
